// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared states, stall patterns and exception codes for pipe_ctrl
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_FLUSH   = 2'd1,
        PC_RECOVER = 2'd2
    } pc_state_e;

    localparam logic [5:0] StallNone   = 6'b000000;
    localparam logic [5:0] StallIf     = 6'b000011;
    localparam logic [5:0] StallId     = 6'b000111;
    localparam logic [5:0] StallEx     = 6'b001111;
    localparam logic [5:0] StallMem    = 6'b011111;
    localparam logic [5:0] StallFreeze = 6'b111111;

    localparam logic [31:0] ExcEret = 32'h0000_000e;

    // A stalled stage also holds everything upstream of it, so the deepest requester wins.
    function automatic logic [5:0] merge_stall(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem) begin
            return StallMem;
        end else if (req_ex) begin
            return StallEx;
        end else if (req_id) begin
            return StallId;
        end else if (req_if) begin
            return StallIf;
        end
        return StallNone;
    endfunction

endpackage

// File: rtl/stall_wdt.sv
// rtl/stall_wdt.sv - consecutive-stall watchdog counter; TIMEOUT of 0 never expires
module stall_wdt #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_any_i,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = stall_any_i ? cnt_q + 32'd1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (TIMEOUT != 0) && run_i && stall_any_i && (cnt_q == 32'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, exception sequencing and stall watchdog for the 5-stage core
// Optional stall-cycle performance counter enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY     = 32'h0000_0020,
    parameter int unsigned STALL_TIMEOUT = 1023,
    parameter logic [31:0] WDT_ENTRY     = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdt_o,
    output logic [31:0] stall_cycles_o
);

    pc_state_e   state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        wdt_flag_q, wdt_flag_d;
    logic [5:0]  merged;
    logic        wdt_expire;
    logic        wdt_clr;
    logic        exc_take;

    assign merged   = merge_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    // MEM is frozen while it waits on the data bus, so the exception is simply retried later.
    assign exc_take = (excepttype_i != '0) && !stallreq_mem;

    stall_wdt #(
        .TIMEOUT (STALL_TIMEOUT)
    ) u_stall_wdt (
        .clk         (clk),
        .rst_n       (rst),
        .stall_any_i (merged != StallNone),
        .run_i       (state_q == PC_RUN),
        .clr_i       (wdt_clr),
        .expire_o    (wdt_expire)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        wdt_flag_d = wdt_flag_q;
        wdt_clr    = 1'b0;
        stall      = StallNone;
        flush      = 1'b0;
        new_pc     = '0;
        wdt_o      = 1'b0;
        case (state_q)
            PC_RUN: begin
                if (exc_take) begin
                    stall    = StallFreeze;
                    target_d = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_ENTRY;
                    wdt_clr  = 1'b1;
                    state_d  = PC_FLUSH;
                end else if (wdt_expire) begin
                    stall      = StallFreeze;
                    target_d   = WDT_ENTRY;
                    wdt_flag_d = 1'b1;
                    wdt_clr    = 1'b1;
                    state_d    = PC_FLUSH;
                end else begin
                    stall = merged;
                end
            end
            PC_FLUSH: begin
                flush      = 1'b1;
                new_pc     = target_q;
                wdt_o      = wdt_flag_q;
                wdt_flag_d = 1'b0;
                state_d    = PC_RECOVER;
            end
            PC_RECOVER: begin
                stall   = merged;
                state_d = PC_RUN;
            end
            default: begin
                state_d = PC_RUN;
            end
        endcase
        // Outputs are combinational from the inputs, so hold them quiet while reset is low.
        if (!rst) begin
            stall  = StallNone;
            flush  = 1'b0;
            new_pc = '0;
            wdt_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PC_RUN;
            target_q   <= '0;
            wdt_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            wdt_flag_q <= wdt_flag_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Merged patterns never stop WB, so StallFreeze identifies the exception freeze cycle.
    always_comb begin
        perf_d = perf_q;
        if (stall[0] && (stall != StallFreeze) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycles_o = perf_q;
`else
    assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Merges stall requests from IF/ID/EX/MEM into the 6-bit stall bus consumed by the pc_reg, if_id, id_ex, ex_mem and mem_wb registers.
- Sequences exception entry: freeze, then a one-cycle flush with redirect PC, then recovery.
- Stall watchdog forces an exception when the pipeline stays stalled too long.

Parameters:
- EXC_ENTRY, 32'h0000_0020, redirect PC for all exceptions except eret and watchdog.
- STALL_TIMEOUT, 1023, consecutive stalled cycles before the watchdog fires; 0 disables it.
- WDT_ENTRY, 32'h0000_0040, redirect PC for a watchdog exception.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- stallreq_if  in  1  instruction-bus wait
- stallreq_id  in  1  load-use / branch hazard
- stallreq_ex  in  1  multi-cycle mul/div
- stallreq_mem  in  1  data-bus wait
- excepttype_i  in  32  exception code from MEM; 0 = none, 32'h0000_000e = eret
- cp0_epc_i  in  32  EPC from CP0
- stall  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = stop
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect target, valid when flush=1
- wdt_o  out  1  one-cycle pulse: watchdog exception taken
- stall_cycles_o  out  32  optional performance counter

Behaviour:
- Reset (rst=0, async): state=RUN, wdt counter=0, latched target=0, stall=0, flush=0, new_pc=0, wdt_o=0, stall_cycles_o=0.
- Stall merge (combinational, used in RUN and RECOVER), highest priority first:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- FSM, three states:
  - RUN:
    - if excepttype_i≠0 and stallreq_mem=0: stall=6'b111111 this cycle; latch target (cp0_epc_i if eret, else EXC_ENTRY); next state FLUSH.
    - else if watchdog expires: stall=6'b111111, latch WDT_ENTRY, set wdt flag; next state FLUSH.
    - else: merged stall; stay in RUN.
    - An exception during stallreq_mem=1 waits; MEM is frozen, so excepttype_i stays presented.
  - FLUSH: exactly one cycle. flush=1, stall=0, new_pc=latched target, wdt_o=wdt flag; wdt flag cleared. Next state RECOVER.
  - RECOVER: one cycle. excepttype_i ignored (bubbles); merged stall applied. Next state RUN.
- new_pc=0 and flush=0 in every state except FLUSH.
- Watchdog (RUN only):
  - Counter increments when merged stall≠0 and clears when it is 0.
  - Fires when counter reaches STALL_TIMEOUT−1 with stall still requested.
  - Counter clears on entering FLUSH. No saturation wrap, since the counter clears on fire.
- Priority within one RUN cycle: exception > watchdog > stall merge.
- Reset asserted mid-FLUSH or mid-RECOVER aborts immediately to RUN with all outputs zero.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: stall_cycles_o counts cycles with stall[0]=1, excluding the exception freeze cycle. Saturates at 32'hFFFF_FFFF and clears on reset only.
- Undefined: stall_cycles_o tied to 32'h0 and no counter flops are generated.

Decomposition:
- Shared defines header additions:
  - state encodings PC_RUN / PC_FLUSH / PC_RECOVER (2 bits)
  - stall pattern constants StallMem / StallEx / StallId / StallIf
  - ExcEret = 32'h0000_000e
- Sub-module stall_wdt holds the watchdog counter: inputs stall_any, run, clr; output expire.
- Stall merge and FSM stay in pipe_ctrl.

Test Plan:
- stallreq_ex=1 for 3 cycles, others 0 → stall=6'b001111 for 3 cycles, flush=0, then 6'b000000.
- stallreq_id=1 and stallreq_mem=1 together → stall=6'b011111 (mem wins).
- excepttype_i=32'h8 with stallreq_mem=0 → cycle T stall=6'b111111; T+1 flush=1, new_pc=32'h20, stall=0; T+2 excepttype_i ignored; T+3 back in RUN.
- excepttype_i=32'he, cp0_epc_i=32'h0000_1234, stallreq_mem=1 for 2 cycles then 0 → stall=6'b011111 for 2 cycles, freeze, then flush with new_pc=32'h1234.
- STALL_TIMEOUT=8, stallreq_if held high → after 8 stalled cycles: freeze, flush with new_pc=32'h40 and wdt_o=1 for one cycle; counter restarts.
- Reset pulsed during FLUSH → flush, new_pc, stall drop to 0 asynchronously; with PIPE_CTRL_PERF_EN, stall_cycles_o=0 after reset and increments by 1 per stalled cycle.
